imm_ext_stage: RTL and testbench
================================

// Module: imm_ext_stage
// PURPOSE
//  Parametrised, registered immediate-extension stage for the pipelined CPU ID path.
//  Supersedes the fixed 16->32 upper-immediate placer.
//  Expands an IMM_W-bit instruction field to DATA_W bits in one of five modes.
//  Passes a TAG (PC/rd) alongside; valid/ready handshake with 2-entry skid buffer, flush.
// PARAMETERS
//  DATA_W  32  result width; must be >= IMM_W+2
//  IMM_W   16  immediate field width; must be >= 11
//  TAG_W   32  sideband tag width, carried unmodified
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  flush      in   1       synchronous kill of all held entries (branch mispredict)
//  in_valid   in   1       upstream presents imm/mode/tag
//  in_ready   out  1       stage can accept this cycle
//  in_imm     in   IMM_W   raw immediate field
//  in_mode    in   3       extension mode (see BEHAVIOUR)
//  in_tag     in   TAG_W   sideband
//  out_valid  out  1       out_data/out_tag/out_err valid
//  out_ready  in   1       downstream accepts
//  out_data   out  DATA_W  extended immediate
//  out_tag    out  TAG_W   tag of same entry
//  out_err    out  1       entry had illegal mode
// BEHAVIOUR
//  Modes: 0 SEXT = sign-extend imm.
//         1 ZEXT = zero-extend imm.
//         2 LUI  = {imm, (DATA_W-IMM_W) zeros}.
//         3 BR   = sign-extend imm, then shift left 2 (low 2 bits 0).
//         4 SHAMT = zero-extend imm[10:6].
//         5-7 illegal: data = 0, err = 1.
//  Extension is combinational on input; the result is registered. Latency is exactly 1 cycle.
//   An accepted input appears at out_* on the next cycle when the stage was empty.
//  Storage: main reg (drives out_*) + skid reg. Count 0..2 held entries.
//  Accept = in_valid & in_ready. Drain = out_valid & out_ready.
//  in_ready = !skid_full; it is a registered signal and does not depend on out_ready.
//  Count 0: accept -> main.
//  Count 1: accept & drain -> main replaced. Accept only -> skid. Drain only -> empty.
//  Count 2: in_ready=0. Drain -> skid moves to main, skid clears.
//  FIFO order is preserved at all times.
//  Outputs hold stable while out_valid & !out_ready. No change to data/tag/err.
//  flush: next cycle out_valid=0, skid empty, in_ready=1.
//   An input accepted in the flush cycle is discarded. Flush dominates accept and drain.
//  rst (any time, incl. mid-transfer): out_valid=0, skid empty, in_ready=0 while rst=1,
//   in_ready=1 first cycle after release. out_data=0, out_tag=0, out_err=0.
//  Data regs are only written on load; no X on outputs after reset.
//  No arithmetic overflow is possible. BR shift discards the top 2 bits of the sign-extended value.
// STRUCTURE
//  Shared header imm_defs.vh: mode localparams IMM_SEXT..IMM_SHAMT, IMM_MODE_W=3.
//  Sub-module imm_ext_fn: combinational {mode, imm} -> {data, err}, parametrised DATA_W/IMM_W.
//   Reusable in EX for forwarding checks.
//  Top level holds the main/skid regs, count FSM (EMPTY/ONE/FULL) and handshake logic.
// TESTING
//  rst pulse mid-stream with count=2 -> next cycle out_valid=0, all outs 0.
//   After release, in_ready=1.
//  Modes, out_ready=1, imm=16'h8001:
//   SEXT -> FFFF8001. ZEXT -> 00008001. LUI -> 80010000. BR -> FFFE0004.
//   SHAMT (imm=16'h07C0) -> 0000001F. Mode 6 -> 0, err=1.
//  Back-pressure: push tags 1,2,3 with out_ready=0 -> in_ready drops after tag 2, tag 3 held off.
//   Release -> outputs 1,2,3 in order, no loss or duplicates.
//  Stream: in_valid=1 and out_ready=1 continuously, 100 entries -> one result per cycle,
//   latency 1, in_ready never 0.
//  flush with count=2 plus simultaneous in_valid -> next cycle out_valid=0, in_ready=1.
//   The flushed input never appears.
//  Random in_valid/out_ready, DATA_W=64 IMM_W=12 -> scoreboard match vs reference model,
//   out_* stable under stall.

Source files
------------

// File: rtl/imm_ext_stage_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and
// the occupancy states of the main/skid buffer.
package imm_ext_stage_pkg;

  localparam int IMM_MODE_W = 3;

  localparam logic [IMM_MODE_W-1:0] IMM_SEXT  = 3'd0;
  localparam logic [IMM_MODE_W-1:0] IMM_ZEXT  = 3'd1;
  localparam logic [IMM_MODE_W-1:0] IMM_LUI   = 3'd2;
  localparam logic [IMM_MODE_W-1:0] IMM_BR    = 3'd3;
  localparam logic [IMM_MODE_W-1:0] IMM_SHAMT = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/imm_ext_fn.sv
// Combinational immediate expander {mode, imm} -> {data, err}; also usable
// in EX for forwarding checks.
module imm_ext_fn
  import imm_ext_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [IMM_MODE_W-1:0] mode,
  input  logic [IMM_W-1:0]      imm,
  output logic [DATA_W-1:0]     data,
  output logic                  err
);

  logic [DATA_W-1:0] sext_w;

  assign sext_w = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (mode)
      IMM_SEXT:  data = sext_w;
      IMM_ZEXT:  data = {{(DATA_W-IMM_W){1'b0}}, imm};
      IMM_LUI:   data = {imm, {(DATA_W-IMM_W){1'b0}}};
      // Top two bits of the sign-extended value fall off the end.
      IMM_BR:    data = {sext_w[DATA_W-3:0], 2'b00};
      IMM_SHAMT: data = {{(DATA_W-5){1'b0}}, imm[10:6]};
      default:   err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage with valid/ready handshake, a
// two-entry main/skid buffer and a synchronous flush.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | main holds the head entry, skid free
// ST_FULL  | main and skid both held, in_ready=0
module imm_ext_stage
  import imm_ext_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [IMM_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  state_e state_q, state_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;

  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [TAG_W-1:0]  main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic              main_err_q, main_err_d, skid_err_q, skid_err_d;

  logic [DATA_W-1:0] ext_data;
  logic              ext_err;
  logic              accept, drain;

  imm_ext_fn #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W)
  ) u_fn (
    .mode(in_mode),
    .imm (in_imm),
    .data(ext_data),
    .err (ext_err)
  );

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_tag_d  = main_tag_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    skid_err_d  = skid_err_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_data_d = ext_data;
            main_tag_d  = in_tag;
            main_err_d  = ext_err;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_data_d = ext_data;
            main_tag_d  = in_tag;
            main_err_d  = ext_err;
          end else if (accept) begin
            skid_data_d = ext_data;
            skid_tag_d  = in_tag;
            skid_err_d  = ext_err;
            state_d     = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_data_d = skid_data_q;
            main_tag_d  = skid_tag_q;
            main_err_d  = skid_err_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Handshake flags follow the next occupancy so they can be registered.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      main_data_q <= '0;
      main_tag_q  <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_tag_q  <= main_tag_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_tag   = main_tag_q;
  assign out_err   = main_err_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: directed vectors on a 32/16 instance, randomized
// scoreboard run on a 64/12 instance against an arithmetic reference model.
module tb_imm_ext_stage;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit data, 16-bit immediate instance
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [15:0] a_in_imm;
  logic [2:0]  a_in_mode;
  logic [31:0] a_in_tag, a_out_tag, a_out_data;

  // 64-bit data, 12-bit immediate instance
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [11:0] b_in_imm;
  logic [2:0]  b_in_mode;
  logic [15:0] b_in_tag, b_out_tag;
  logic [63:0] b_out_data;

  imm_ext_stage #(.DATA_W(32), .IMM_W(16), .TAG_W(32)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_imm(a_in_imm),
    .in_mode(a_in_mode), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .out_err(a_out_err)
  );

  imm_ext_stage #(.DATA_W(64), .IMM_W(12), .TAG_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm),
    .in_mode(b_in_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .out_err(b_out_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: extension computed with plain integer arithmetic modulo 2**dw.
  function automatic void ref_ext(input int dw, input int iw, input logic [63:0] imm,
                                  input int mode, output logic [63:0] d, output logic e);
    logic [63:0] mask, s;
    mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
    s    = (imm >= (64'd1 << (iw - 1))) ? imm - (64'd1 << iw) : imm;
    e    = 1'b0;
    case (mode)
      0:       d = s & mask;
      1:       d = imm;
      2:       d = (imm * (64'd1 << (dw - iw))) & mask;
      3:       d = (s * 64'd4) & mask;
      4:       d = (imm / 64) % 32;
      default: begin d = 64'd0; e = 1'b1; end
    endcase
  endfunction

  typedef struct {
    logic [15:0] imm;
    logic [2:0]  mode;
    logic [31:0] data;
    logic        err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  typedef struct {
    logic [63:0] data;
    logic [15:0] tag;
    logic        err;
  } exp_t;

  exp_t sb[$];

  initial begin
    logic [63:0] pd, ed;
    logic        pe, ee;
    logic [31:0] ptag;
    logic        stall_prev;
    logic [63:0] hold_d;
    logic [15:0] hold_t;
    logic        hold_e;
    logic        v, r, f;
    exp_t        x;

    vecs[0]  = '{16'h8001, 3'd0, 32'hFFFF8001, 1'b0};
    vecs[1]  = '{16'h8001, 3'd1, 32'h00008001, 1'b0};
    vecs[2]  = '{16'h8001, 3'd2, 32'h80010000, 1'b0};
    vecs[3]  = '{16'h8001, 3'd3, 32'hFFFE0004, 1'b0};
    vecs[4]  = '{16'h07C0, 3'd4, 32'h0000001F, 1'b0};
    vecs[5]  = '{16'h8001, 3'd6, 32'h00000000, 1'b1};
    vecs[6]  = '{16'hFFFF, 3'd5, 32'h00000000, 1'b1};
    vecs[7]  = '{16'h1234, 3'd7, 32'h00000000, 1'b1};
    vecs[8]  = '{16'h7FFF, 3'd0, 32'h00007FFF, 1'b0};
    vecs[9]  = '{16'h7FFF, 3'd3, 32'h0001FFFC, 1'b0};
    vecs[10] = '{16'h0001, 3'd2, 32'h00010000, 1'b0};
    vecs[11] = '{16'hFFFF, 3'd4, 32'h0000001F, 1'b0};
    vecs[12] = '{16'h0040, 3'd4, 32'h00000001, 1'b0};

    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_in_imm = '0; a_in_mode = '0; a_in_tag = '0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_imm = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, a_in_ready}, 64'd0);
    chk("rst_out_data",  {32'd0, a_out_data}, 64'd0);
    chk("rst_out_tag",   {32'd0, a_out_tag}, 64'd0);
    chk("rst_out_err",   {63'd0, a_out_err}, 64'd0);
    chk("rst_b_valid",   {63'd0, b_out_valid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready",   {63'd0, a_in_ready}, 64'd1);
    chk("rel_b_in_ready", {63'd0, b_in_ready}, 64'd1);

    // Directed vector table, streamed one per cycle
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) begin
        chk("vec_valid", {63'd0, a_out_valid}, 64'd1);
        chk("vec_data",  {32'd0, a_out_data}, {32'd0, vecs[i-1].data});
        chk("vec_err",   {63'd0, a_out_err}, {63'd0, vecs[i-1].err});
        chk("vec_tag",   {32'd0, a_out_tag}, 64'(100 + i - 1));
      end
      chk("vec_in_ready", {63'd0, a_in_ready}, 64'd1);
      if (i < NV) begin
        a_in_valid = 1; a_in_imm = vecs[i].imm; a_in_mode = vecs[i].mode; a_in_tag = 32'(100 + i);
      end else begin
        a_in_valid = 0;
      end
      @(negedge clk);
    end
    chk("vec_drained", {63'd0, a_out_valid}, 64'd0);

    // 100-entry continuous stream, latency 1
    pd = '0; pe = 0; ptag = '0;
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        chk("str_valid", {63'd0, a_out_valid}, 64'd1);
        chk("str_data",  {32'd0, a_out_data}, pd);
        chk("str_err",   {63'd0, a_out_err}, {63'd0, pe});
        chk("str_tag",   {32'd0, a_out_tag}, {32'd0, ptag});
      end
      chk("str_in_ready", {63'd0, a_in_ready}, 64'd1);
      if (i < 100) begin
        a_in_valid = 1;
        a_in_imm   = 16'($urandom);
        a_in_mode  = 3'($urandom_range(0, 7));
        a_in_tag   = $urandom;
        ref_ext(32, 16, {48'd0, a_in_imm}, int'(a_in_mode), pd, pe);
        ptag = a_in_tag;
      end else begin
        a_in_valid = 0;
      end
      @(negedge clk);
    end

    // Back-pressure: tags 1,2,3 with out_ready low
    a_out_ready = 0; a_in_valid = 1; a_in_mode = 3'd1; a_in_imm = 16'h0011; a_in_tag = 1;
    @(negedge clk);
    chk("bp_ready1", {63'd0, a_in_ready}, 64'd1);
    chk("bp_tag1",   {32'd0, a_out_tag}, 64'd1);
    a_in_tag = 2;
    @(negedge clk);
    chk("bp_full_ready", {63'd0, a_in_ready}, 64'd0);
    a_in_tag = 3;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_ready", {63'd0, a_in_ready}, 64'd0);
      chk("bp_hold_valid", {63'd0, a_out_valid}, 64'd1);
      chk("bp_hold_tag",   {32'd0, a_out_tag}, 64'd1);
      chk("bp_hold_data",  {32'd0, a_out_data}, 64'h11);
    end
    a_out_ready = 1;
    @(negedge clk);
    chk("bp_out2",    {32'd0, a_out_tag}, 64'd2);
    chk("bp_ready2",  {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    chk("bp_out3",    {32'd0, a_out_tag}, 64'd3);
    chk("bp_valid3",  {63'd0, a_out_valid}, 64'd1);
    a_in_valid = 0;
    @(negedge clk);
    chk("bp_empty",   {63'd0, a_out_valid}, 64'd0);

    // Flush with two held entries plus a simultaneous input
    a_out_ready = 0; a_in_valid = 1; a_in_tag = 10;
    @(negedge clk);
    a_in_tag = 11;
    @(negedge clk);
    chk("fl2_full", {63'd0, a_in_ready}, 64'd0);
    a_flush = 1; a_in_tag = 12;
    @(negedge clk);
    a_flush = 0; a_in_valid = 0;
    chk("fl2_valid", {63'd0, a_out_valid}, 64'd0);
    chk("fl2_ready", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    chk("fl2_ghost", {63'd0, a_out_valid}, 64'd0);

    // Flush with one held entry while an input is accepted
    a_in_valid = 1; a_in_tag = 20;
    @(negedge clk);
    chk("fl1_valid_pre", {63'd0, a_out_valid}, 64'd1);
    chk("fl1_tag_pre",   {32'd0, a_out_tag}, 64'd20);
    a_flush = 1; a_in_tag = 21;
    @(negedge clk);
    a_flush = 0; a_in_valid = 0;
    chk("fl1_valid", {63'd0, a_out_valid}, 64'd0);
    chk("fl1_ready", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    chk("fl1_ghost", {63'd0, a_out_valid}, 64'd0);

    // Reset mid-stream with two held entries
    a_in_valid = 1; a_in_mode = 3'd6; a_in_imm = 16'h0001; a_in_tag = 5;
    @(negedge clk);
    a_in_mode = 3'd1; a_in_imm = 16'h1234; a_in_tag = 6;
    @(negedge clk);
    a_in_valid = 0;
    chk("mrst_pre_err", {63'd0, a_out_err}, 64'd1);
    chk("mrst_pre_tag", {32'd0, a_out_tag}, 64'd5);
    chk("mrst_pre_full", {63'd0, a_in_ready}, 64'd0);
    rst = 1;
    @(negedge clk);
    chk("mrst_valid", {63'd0, a_out_valid}, 64'd0);
    chk("mrst_data",  {32'd0, a_out_data}, 64'd0);
    chk("mrst_tag",   {32'd0, a_out_tag}, 64'd0);
    chk("mrst_err",   {63'd0, a_out_err}, 64'd0);
    chk("mrst_ready", {63'd0, a_in_ready}, 64'd0);
    rst = 0;
    a_out_ready = 1;
    @(negedge clk);
    chk("mrst_rel_ready", {63'd0, a_in_ready}, 64'd1);
    chk("mrst_rel_valid", {63'd0, a_out_valid}, 64'd0);

    // Randomized scoreboard run on the 64/12 instance
    stall_prev = 0; hold_d = '0; hold_t = '0; hold_e = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_out_valid", {63'd0, b_out_valid}, {63'd0, (sb.size() > 0)});
      chk("rnd_in_ready",  {63'd0, b_in_ready},  {63'd0, (sb.size() < 2)});
      if (stall_prev) begin
        chk("rnd_stall_data", b_out_data, hold_d);
        chk("rnd_stall_tag",  {48'd0, b_out_tag}, {48'd0, hold_t});
        chk("rnd_stall_err",  {63'd0, b_out_err}, {63'd0, hold_e});
      end
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 60) == 0);
      b_in_valid  = v;
      b_out_ready = r;
      b_flush     = f;
      b_in_imm    = 12'($urandom);
      b_in_mode   = 3'($urandom_range(0, 7));
      b_in_tag    = 16'($urandom);
      if (f) begin
        sb.delete();
      end else begin
        if (b_out_valid && r && sb.size() > 0) begin
          x = sb.pop_front();
          chk("rnd_data", b_out_data, x.data);
          chk("rnd_tag",  {48'd0, b_out_tag}, {48'd0, x.tag});
          chk("rnd_err",  {63'd0, b_out_err}, {63'd0, x.err});
        end
        if (v && b_in_ready) begin
          ref_ext(64, 12, {52'd0, b_in_imm}, int'(b_in_mode), ed, ee);
          x.data = ed; x.tag = b_in_tag; x.err = ee;
          sb.push_back(x);
        end
      end
      stall_prev = b_out_valid && !r && !f;
      hold_d = b_out_data; hold_t = b_out_tag; hold_e = b_out_err;
      @(negedge clk);
    end
    b_in_valid = 0; b_flush = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
